// File: rtl/link_peer.sv
// Far-end serial link peer: exchanges one byte per transfer over SCK/SIN/SOUT,
// as clock slave (mode=0) or clock master (mode=1). LINK_PEER_TIMEOUT_EN adds a slave idle-SCK abort.
module link_peer #(
    parameter int unsigned CLK_DIV        = 256,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    input  logic       sck_in,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic       sin,
    output logic       sout,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("link_peer: CLK_DIV and TIMEOUT_CYCLES must both be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic             tx_ready_q, tx_ready_d;
    logic             sck_out_q, sck_out_d;
    logic             sck_oe_q, sck_oe_d;
    logic             sout_q, sout_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic sck_meta_q, sck_meta_d;
    logic sck_sync_q, sck_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic sin_meta_q, sin_meta_d;
    logic sin_sync_q, sin_sync_d;

    logic sck_rise;
    logic sck_fall;
    logic do_rise;
    logic do_fall;

`ifdef LINK_PEER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            rx_err_q, rx_err_d;
`endif

    // Edges are taken on the synchronised SCK; SCK idles high.
    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q & sck_prev_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        tx_ready_d = tx_ready_q;
        sck_out_d  = sck_out_q;
        sck_oe_d   = sck_oe_q;
        sout_d     = sout_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
`ifdef LINK_PEER_TIMEOUT_EN
        to_cnt_d   = '0;
        rx_err_d   = 1'b0;
`endif

        sck_meta_d = sck_in;
        sck_sync_d = sck_meta_q;
        sck_prev_d = sck_sync_q;
        sin_meta_d = sin;
        sin_sync_d = sin_meta_q;

        case (state_q)
            ST_IDLE: begin
                tx_ready_d = 1'b1;
                sout_d     = 1'b1;
                sck_oe_d   = 1'b0;
                sck_out_d  = 1'b1;
                if (tx_load) begin
                    tx_sr_d    = tx_data;
                    sout_d     = tx_data[7];
                    mode_d     = mode;
                    bit_cnt_d  = 4'd0;
                    div_d      = '0;
                    tx_ready_d = 1'b0;
                    state_d    = ST_ARMED;
                end
            end

            ST_ARMED: begin
                // The opening fall only frames the byte; bit7 is already on sout.
                if (mode_q) begin
                    sck_oe_d  = 1'b1;
                    sck_out_d = 1'b0;
                    div_d     = '0;
                    state_d   = ST_SHIFT;
                end else if (sck_fall) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (mode_q) begin
                    if (div_q == DIV_W'(CLK_DIV - 1)) begin
                        div_d = '0;
                        if (!sck_out_q) begin
                            sck_out_d = 1'b1;
                            do_rise   = 1'b1;
                        end else begin
                            sck_out_d = 1'b0;
                            do_fall   = 1'b1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end else begin
                    do_rise = sck_rise;
                    do_fall = sck_fall && (bit_cnt_q != 4'd0);
                end

                if (do_rise) begin
                    rx_sr_d   = {rx_sr_q[6:0], sin_sync_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_DONE;
                    end
                end
                if (do_fall) begin
                    tx_sr_d = {tx_sr_q[6:0], 1'b1};
                    sout_d  = tx_sr_q[6];
                end

`ifdef LINK_PEER_TIMEOUT_EN
                // Counter holds cycles since the last sync edge; abort once it would reach the limit.
                if (!mode_q) begin
                    if (sck_rise || sck_fall) begin
                        to_cnt_d = TO_W'(1);
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rx_err_d   = 1'b1;
                        sout_d     = 1'b1;
                        sck_oe_d   = 1'b0;
                        sck_out_d  = 1'b1;
                        tx_ready_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
`endif
            end

            ST_DONE: begin
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
                sout_d     = 1'b1;
                sck_oe_d   = 1'b0;
                sck_out_d  = 1'b1;
                tx_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            bit_cnt_q  <= 4'd0;
            div_q      <= '0;
            tx_sr_q    <= 8'hFF;
            rx_sr_q    <= 8'hFF;
            tx_ready_q <= 1'b1;
            sck_out_q  <= 1'b1;
            sck_oe_q   <= 1'b0;
            sout_q     <= 1'b1;
            rx_data_q  <= 8'hFF;
            rx_valid_q <= 1'b0;
            sck_meta_q <= 1'b1;
            sck_sync_q <= 1'b1;
            sck_prev_q <= 1'b1;
            sin_meta_q <= 1'b1;
            sin_sync_q <= 1'b1;
`ifdef LINK_PEER_TIMEOUT_EN
            to_cnt_q   <= '0;
            rx_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            tx_ready_q <= tx_ready_d;
            sck_out_q  <= sck_out_d;
            sck_oe_q   <= sck_oe_d;
            sout_q     <= sout_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_meta_q <= sck_meta_d;
            sck_sync_q <= sck_sync_d;
            sck_prev_q <= sck_prev_d;
            sin_meta_q <= sin_meta_d;
            sin_sync_q <= sin_sync_d;
`ifdef LINK_PEER_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            rx_err_q   <= rx_err_d;
`endif
        end
    end

    assign tx_ready = tx_ready_q;
    assign sck_out  = sck_out_q;
    assign sck_oe   = sck_oe_q;
    assign sout     = sout_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef LINK_PEER_TIMEOUT_EN
    assign rx_err   = rx_err_q;
`else
    assign rx_err   = 1'b0;
`endif

endmodule

// File: doc/link_peer.md
Name: link_peer

Overview:
- Behavioural-RTL model of the far end of the DMG serial link cable, i.e. the partner console or peripheral.
- Exchanges one byte per transfer with the DMG serial port over SCK/SIN/SOUT.
- Runs in two modes:
  - slave mode: the DMG drives SCK from its internal clock.
  - master mode: the peer drives SCK, which the DMG sees as an external clock.
- Sits in the testbench top, alongside the CPU, on the link pins.

Parameters:
- CLK_DIV, 256: SCK half-period in clk cycles in master mode. Minimum 2.
- TIMEOUT_CYCLES, 65536: idle-SCK abort limit in slave mode. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = slave (DMG clocks), 1 = master (peer clocks). Sampled only in IDLE.
- tx_data  input  8  byte to send to the DMG.
- tx_load  input  1  one-cycle strobe that latches tx_data and arms a transfer.
- tx_ready  output  1  high when a tx_load will be accepted.
- sck_in  input  1  SCK from the DMG. Asynchronous.
- sck_out  output  1  SCK driven by the peer in master mode.
- sck_oe  output  1  high while the peer drives sck_out.
- sin  input  1  DMG SOUT seen by the peer. Asynchronous.
- sout  output  1  peer data to the DMG SIN.
- rx_data  output  8  last byte received from the DMG.
- rx_valid  output  1  one-cycle strobe when rx_data updates.
- rx_err  output  1  one-cycle strobe on timeout abort.

Behaviour:
- Reset values:
  - tx_ready=1, sck_out=1, sck_oe=0, sout=1, rx_data=8'hFF, rx_valid=0, rx_err=0.
  - State IDLE, bit_cnt=0, divider=0.
- Input synchronisation:
  - sck_in and sin pass through 2-flop synchronisers.
  - SCK edges are detected on the synchronised value. Rise = 0->1, fall = 1->0.
  - Detection latency is 2-3 clk cycles from the pin.
- Protocol:
  - SCK idles high. Data is MSB first.
  - The receiver samples on each SCK rising edge.
  - The transmitter changes data on each SCK falling edge.
- States: IDLE, ARMED, SHIFT, DONE.
- IDLE:
  - tx_ready=1, sout=1.
  - On tx_load: tx_sr<=tx_data, sout<=tx_data[7], latch mode, bit_cnt<=0, tx_ready<=0. Next state ARMED.
- ARMED, slave mode:
  - Wait for the first synchronised SCK fall, then go to SHIFT.
  - sout keeps bit7 (the first fall does not shift).
- ARMED, master mode:
  - Next cycle: sck_oe<=1, sck_out<=0, divider<=0. Next state SHIFT.
- SHIFT, rising edge handling:
  - Rising edge = sync SCK rise in slave mode, or divider expiry that drives sck_out 0->1 in master mode.
  - On each rising edge: rx_sr<={rx_sr[6:0], sin_sync}, bit_cnt++.
  - When bit_cnt reaches 8, go to DONE.
- SHIFT, falling edge handling:
  - On each falling edge after a rise: tx_sr<={tx_sr[6:0],1'b1}, sout<=new tx_sr[7].
- Master clocking:
  - sck_out toggles each CLK_DIV cycles.
  - Exactly 8 low/high pairs, ending high.
- DONE (one cycle):
  - rx_data<=rx_sr, rx_valid=1, sout<=1, sck_oe<=0, sck_out<=1, tx_ready<=1.
  - Next state IDLE.
- Boundary and corner cases:
  - tx_load while tx_ready=0 is ignored. tx_data is not re-latched.
  - SCK edges in IDLE are ignored. sout stays 1, so the DMG receives 8'hFF.
  - In master mode sck_in edges are ignored.
  - A SCK glitch shorter than 2 clk cycles may be missed. This is acceptable.
  - reset asserted mid-transfer returns all outputs to reset values on the next clk edge. No rx_valid is produced and the partial byte is discarded.
  - A tx_load in the same cycle as reset is dropped.
  - rx_valid and rx_err are never high together.

Optional Feature:
- Macro: LINK_PEER_TIMEOUT_EN.
- With the macro, in slave mode SHIFT:
  - A counter clears on every sync SCK edge.
  - If it reaches TIMEOUT_CYCLES, the peer aborts: rx_err pulses for 1 cycle, outputs return to idle values, rx_data is unchanged, and the state goes to IDLE.
  - ARMED never times out.
- Without the macro:
  - No counter exists and rx_err is tied 0.
  - SHIFT waits indefinitely.

Test Plan:
- Slave exchange:
  - Stimulus: load 8'hA5, then the DMG drives 8 SCK cycles (8192 Hz equivalent) sending 8'h3C.
  - Response: the DMG sees 8'hA5 on sout, rx_data=8'h3C with a single rx_valid pulse, tx_ready returns high.
- Master exchange:
  - Stimulus: CLK_DIV=4, mode=1, load 8'h81, sin driven 8'hF0.
  - Response: exactly 8 sck_out pulses of 8 clk cycles each, sck_oe high only during the transfer, rx_data=8'hF0, sout sequence 1,0,0,0,0,0,0,1.
- Unarmed peer:
  - Stimulus: the DMG clocks 8 bits with no tx_load.
  - Response: the DMG receives 8'hFF, rx_valid stays 0, state stays IDLE.
- Busy load:
  - Stimulus: tx_load 8'h55 after 3 bits of a 8'hA5 transfer.
  - Response: the load is ignored, the transfer completes sending 8'hA5, and a subsequent load of 8'h55 is accepted.
- Reset mid-transfer:
  - Stimulus: reset after 5 rising edges.
  - Response: next cycle sout=1, sck_oe=0, tx_ready=1, no rx_valid, rx_data=8'hFF.
- Timeout (LINK_PEER_TIMEOUT_EN, TIMEOUT_CYCLES=100):
  - Stimulus: SCK stops after 3 bits.
  - Response: rx_err pulses exactly 100 cycles after the last sync edge, rx_data is unchanged, state is IDLE.
